// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the "1010" detector word controller.
package seq_det_pkg;

    localparam int PATTERN_LEN = 4;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SHIFT  = 4'b0010,
        DRAIN  = 4'b0100,
        REPORT = 4'b1000
    } state_t;

    // Clamp a + b to max_val; the 33-bit sum keeps the carry out visible.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/seq_det_ser.sv
// Word serializer: loads a W-bit word and presents one bit per shift in the
// selected order, with a bit index and a last-bit flag.
module seq_det_ser #(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [W-1:0]     i_data,
    input  logic             i_lsb_first,
    output logic             o_bit,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    logic [W-1:0]     r_data;
    logic             r_lsb_first;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     w_next;

    // The current bit always sits at the end facing the chosen direction.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_next
            if (gi == 0) begin : g_lo
                assign w_next[gi] = r_lsb_first ? r_data[1] : 1'b0;
            end else if (gi == W - 1) begin : g_hi
                assign w_next[gi] = r_lsb_first ? 1'b0 : r_data[W-2];
            end else begin : g_mid
                assign w_next[gi] = r_lsb_first ? r_data[gi+1] : r_data[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data      <= '0;
            r_lsb_first <= 1'b0;
            r_idx       <= '0;
        end else if (i_load) begin
            r_data      <= i_data;
            r_lsb_first <= i_lsb_first;
            r_idx       <= '0;
        end else if (i_shift) begin
            r_data      <= w_next;
            r_idx       <= r_idx + IDX_W'(1);
        end
    end

    assign o_bit  = r_lsb_first ? r_data[0] : r_data[W-1];
    assign o_idx  = r_idx;
    assign o_last = (r_idx == IDX_W'(W - 1));

endmodule

// File: rtl/seq_det_ctrl.sv
// Schedules words through an external "1010" detector and reports per-word
// match count, first-match index and a saturating running total.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W + 1),
    parameter int IDX_W = $clog2(W),
    parameter int TOT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_lsb_first,
    output logic             det_din,
    output logic             det_reset,
    input  logic             det_dout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_first_idx,
    input  logic             tot_clr,
    output logic [TOT_W-1:0] tot_count
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_hit;
    logic [IDX_W-1:0] r_first_idx;
    logic [TOT_W-1:0] r_tot;

    logic             w_load;
    logic             w_shift;
    logic             w_bit;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    logic             w_sample;
    logic             w_hit_now;
    logic [IDX_W-1:0] w_attr_idx;
    logic [CNT_W-1:0] w_count_next;

    assign w_load  = (r_state == IDLE) && in_valid;
    assign w_shift = (r_state == SHIFT);

    seq_det_ser #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_ser (
        .i_clk       (clock),
        .i_rst_n     (reset_n),
        .i_load      (w_load),
        .i_shift     (w_shift),
        .i_data      (in_data),
        .i_lsb_first (in_lsb_first),
        .o_bit       (w_bit),
        .o_idx       (w_idx),
        .o_last      (w_last)
    );

    // det_dout lags the driven bit by one cycle, so credit the previous index.
    assign w_sample     = (w_shift && (w_idx != '0)) || (r_state == DRAIN);
    assign w_hit_now    = w_sample && det_dout;
    assign w_attr_idx   = (r_state == DRAIN) ? IDX_W'(W - 1) : (w_idx - IDX_W'(1));
    assign w_count_next = r_count + CNT_W'(w_hit_now);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_hit       <= 1'b0;
            r_first_idx <= '0;
            r_tot       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_count     <= '0;
                        r_hit       <= 1'b0;
                        r_first_idx <= '0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT, DRAIN: begin
                    r_count <= w_count_next;
                    if (w_hit_now && !r_hit) begin
                        r_hit       <= 1'b1;
                        r_first_idx <= w_attr_idx;
                    end
                    if (r_state == DRAIN) begin
                        r_state <= REPORT;
                    end else if (w_last) begin
                        r_state <= DRAIN;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A clear on the update edge wipes the old total before adding.
            if (r_state == DRAIN) begin
                if (tot_clr) begin
                    r_tot <= TOT_W'(w_count_next);
                end else begin
                    r_tot <= TOT_W'(sat_add(32'(r_tot), 32'(w_count_next),
                                            32'({TOT_W{1'b1}})));
                end
            end else if (tot_clr) begin
                r_tot <= '0;
            end
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign res_valid     = (r_state == REPORT);
    assign det_reset     = (r_state != SHIFT);
    assign det_din       = w_shift && w_bit;
    assign res_count     = r_count;
    assign res_hit       = r_hit;
    assign res_first_idx = r_first_idx;
    assign tot_count     = r_tot;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a behavioural "1010" detector and a
// result scoreboard; a second instance with a 4-bit total checks saturation.
module tb_seq_det_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int IDX_W = 3;

    logic             clock        = 1'b0;
    logic             reset_n      = 1'b1;
    logic             in_valid     = 1'b0;
    logic [W-1:0]     in_data      = '0;
    logic             in_lsb_first = 1'b0;
    logic             res_ready    = 1'b1;
    logic             tot_clr      = 1'b0;
    logic             det_dout;

    wire              in_ready, det_din, det_reset, res_valid, res_hit;
    wire [CNT_W-1:0]  res_count;
    wire [IDX_W-1:0]  res_first_idx;
    wire [15:0]       tot_count;

    wire              s_in_ready, s_det_din, s_det_reset, s_res_valid, s_res_hit;
    wire [CNT_W-1:0]  s_res_count;
    wire [IDX_W-1:0]  s_res_first_idx;
    wire [3:0]        s_tot_count;

    int total = 0;
    int bad   = 0;
    int m_tot   = 0;
    int m_tot_s = 0;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [15:0]      tot;
        logic [3:0]       tot_s;
    } exp_t;
    exp_t sb[$];

    seq_det_ctrl #(.W(W), .TOT_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_lsb_first(in_lsb_first), .det_din(det_din),
        .det_reset(det_reset), .det_dout(det_dout), .res_valid(res_valid),
        .res_ready(res_ready), .res_count(res_count), .res_hit(res_hit),
        .res_first_idx(res_first_idx), .tot_clr(tot_clr), .tot_count(tot_count)
    );

    seq_det_ctrl #(.W(W), .TOT_W(4)) u_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_lsb_first(in_lsb_first), .det_din(s_det_din),
        .det_reset(s_det_reset), .det_dout(det_dout), .res_valid(s_res_valid),
        .res_ready(res_ready), .res_count(s_res_count), .res_hit(s_res_hit),
        .res_first_idx(s_res_first_idx), .tot_clr(tot_clr), .tot_count(s_tot_count)
    );

    always #5 clock = ~clock;

    // Detector model: last four bits since its reset, registered match flag.
    logic [3:0] m_hist = '0;
    int         m_n    = 0;
    always @(posedge clock) begin
        if (det_reset) begin
            m_hist <= '0;
            m_n    <= 0;
        end else begin
            m_hist <= {m_hist[2:0], det_din};
            if (m_n < 4) m_n <= m_n + 1;
        end
    end
    assign det_dout = (m_n >= 4) && (m_hist == 4'b1010);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [W-1:0] d, input logic lsb, input int j);
        return lsb ? d[j] : d[W-1-j];
    endfunction

    function automatic void exp_word(input logic [W-1:0] d, input logic lsb,
                                     output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int i = 3; i < W; i++) begin
            if (bit_at(d, lsb, i-3) == 1'b1 && bit_at(d, lsb, i-2) == 1'b0 &&
                bit_at(d, lsb, i-1) == 1'b1 && bit_at(d, lsb, i) == 1'b0) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endfunction

    task automatic send(input logic [W-1:0] d, input logic lsb, input bit clr,
                        input int stall, input string tag);
        int c, f, n;
        exp_t e;
        exp_word(d, lsb, c, f);
        m_tot   = clr ? c : ((m_tot + c > 65535) ? 65535 : m_tot + c);
        m_tot_s = clr ? c : ((m_tot_s + c > 15) ? 15 : m_tot_s + c);
        e.cnt = CNT_W'(c); e.hit = (c != 0); e.idx = IDX_W'(f);
        e.tot = 16'(m_tot); e.tot_s = 4'(m_tot_s);
        sb.push_back(e);

        chk({tag, "_idle_rdy"}, in_ready, 1);
        chk({tag, "_idle_detrst"}, det_reset, 1);
        chk({tag, "_idle_din"}, det_din, 0);
        in_valid = 1'b1; in_data = d; in_lsb_first = lsb;
        res_ready = (stall == 0);
        @(posedge clock); #1;
        in_valid = 1'b0; in_data = W'($urandom); in_lsb_first = ~lsb;

        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            if (n < W) begin
                chk($sformatf("%s_detrst_k%0d", tag, n), det_reset, 0);
                chk($sformatf("%s_din_k%0d", tag, n), det_din, bit_at(d, lsb, n));
            end
            if (clr && n == W) tot_clr = 1'b1;
            @(posedge clock); #1;
            tot_clr = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, n, W + 1);

        e = sb.pop_front();
        for (int s = 0; s <= stall; s++) begin
            chk({tag, "_cnt"}, res_count, e.cnt);
            chk({tag, "_hit"}, res_hit, e.hit);
            chk({tag, "_idx"}, res_first_idx, e.idx);
            chk({tag, "_tot"}, tot_count, e.tot);
            chk({tag, "_tot4"}, s_tot_count, e.tot_s);
            chk({tag, "_rep_rdy"}, in_ready, 0);
            chk({tag, "_rep_detrst"}, det_reset, 1);
            chk({tag, "_rep_din"}, det_din, 0);
            if (s < stall) begin
                @(posedge clock); #1;
                chk({tag, "_stall_valid"}, res_valid, 1);
            end
        end
        res_ready = 1'b1;
        @(posedge clock); #1;
        chk({tag, "_done_valid"}, res_valid, 0);
        chk({tag, "_done_rdy"}, in_ready, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, in_ready, 1);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_cnt"}, res_count, 0);
        chk({tag, "_hit"}, res_hit, 0);
        chk({tag, "_idx"}, res_first_idx, 0);
        chk({tag, "_tot"}, tot_count, 0);
        chk({tag, "_tot4"}, s_tot_count, 0);
        chk({tag, "_detrst"}, det_reset, 1);
        chk({tag, "_din"}, det_din, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals("por");
        reset_n = 1'b1;
        @(posedge clock); #1;

        send(8'hAA, 1'b0, 1'b0, 0, "aa_msb");
        send(8'hAA, 1'b1, 1'b0, 0, "aa_lsb");
        send(8'h02, 1'b0, 1'b0, 0, "w02");
        send(8'h80, 1'b0, 1'b0, 0, "w80");
        send(8'h0A, 1'b1, 1'b0, 5, "stall");

        // Abort a word at k=4 with an asynchronous reset.
        in_valid = 1'b1; in_data = 8'hFF; in_lsb_first = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        m_tot = 0; m_tot_s = 0;
        @(posedge clock); #3;
        reset_n = 1'b1;
        @(posedge clock); #1;

        send(8'h0A, 1'b0, 1'b0, 0, "w0a");
        for (int i = 0; i < 5; i++) send(8'hAA, 1'b0, 1'b0, 0, $sformatf("sat%0d", i));
        send(8'hAA, 1'b0, 1'b1, 0, "clr_upd");

        tot_clr = 1'b1;
        @(posedge clock); #1;
        tot_clr = 1'b0;
        m_tot = 0; m_tot_s = 0;
        chk("clr_alone_tot", tot_count, 16'(m_tot));
        chk("clr_alone_tot4", s_tot_count, 4'(m_tot_s));

        send(8'h5A, 1'b1, 1'b0, 0, "w5a_lsb");
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Controller that schedules parallel words through the existing "1010" serial sequence detector (overlapping detection; synchronous active-high reset; registered Moore output).
- Accepts a W-bit word over a valid/ready handshake and serializes it, one bit per clock, onto the detector input.
- Holds the detector in reset between words, collects its one-cycle-delayed match output, and reports a per-word match count, the first-match bit index, and a saturating running total.
- Sits between a host stream interface and the detector instance at subsystem top level.

Parameters:
- W, 8, data word width in bits (≥4).
- CNT_W, $clog2(W+1), width of the per-word match count.
- IDX_W, $clog2(W), width of the bit index.
- TOT_W, 16, width of the running total counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  W  word to scan.
- in_lsb_first  in  1  shift order, sampled on accept: 1 = bit0 first, 0 = bit W-1 first.
- det_din  out  1  serial bit to detector din.
- det_reset  out  1  to detector reset (active-high, synchronous in the detector).
- det_dout  in  1  detector match output.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_count  out  CNT_W  matches in the word.
- res_hit  out  1  res_count != 0.
- res_first_idx  out  IDX_W  shift-order index of the bit completing the first match; 0 if no hit.
- tot_clr  in  1  synchronous clear of the running total.
- tot_count  out  TOT_W  saturating sum of res_count over all words.

Behaviour:
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch in_data/in_lsb_first, clear the count, hit, and first-index registers; go to SHIFT.
  - SHIFT: lasts exactly W cycles, with bit counter k=0..W-1. det_din = bit k in the chosen order. After k=W-1, go to DRAIN.
  - DRAIN: 1 cycle, then go to REPORT.
  - REPORT: res_valid=1. All res_* outputs are held stable until res_ready=1, then go to IDLE.
- det_reset=1 in every state except SHIFT. det_din=0 outside SHIFT. The detector therefore starts each word from its idle state, and no match ever spans two words.
- Sampling:
  - det_dout reflects the bit driven in the previous cycle.
  - Sample in SHIFT cycles k≥1 (attributed to index k-1) and in DRAIN (attributed to index W-1).
  - Ignore det_dout in SHIFT k=0 and in all other states.
  - On each sampled 1: increment the count. If it is the first hit, record the attributed index in res_first_idx.
- Latency: accepting edge = edge 0. res_valid rises after edge W+1. Minimum period is W+3 cycles per word (with res_ready held high).
- tot_count: on the DRAIN→REPORT edge, tot_count <= min(tot_count + count, 2^TOT_W-1).
  - tot_clr alone: tot_count <= 0.
  - tot_clr coinciding with the update edge: tot_count <= count (clear first, then add).
- in_valid is ignored outside IDLE. in_data and in_lsb_first may change after the accept without effect.
- Asynchronous reset (reset_n=0, any state including mid-SHIFT):
  - Outputs: state=IDLE, in_ready=1, res_valid=0, res_count=0, res_hit=0, res_first_idx=0, tot_count=0, det_reset=1, det_din=0.
  - The in-flight word is discarded.
- No X on outputs after reset. All outputs are registered or decoded from state and registers only; no combinational path from any input to any output.

Decomposition:
- Package seq_det_pkg:
  - state_t enum {IDLE, SHIFT, DRAIN, REPORT} (one-hot encoding).
  - PATTERN_LEN=4 constant.
  - Helper function for saturating add.
- One sub-module, seq_det_ser: a W-bit load/shift register with direction select, bit counter, and last-bit flag. The FSM, sampling, and totals stay in seq_det_ctrl.
- The detector is instantiated alongside the controller at subsystem top, not inside it.

Test Plan:
- in_data=8'hAA, lsb_first=0 (bits 1,0,1,0,1,0,1,0) → res_count=3, res_hit=1, res_first_idx=3, tot_count=3; res_valid rises 9 edges after the accept.
- in_data=8'hAA, lsb_first=1 (bits 0,1,0,1,0,1,0,1) → res_count=2, res_first_idx=4; tot_count accumulates to 5.
- Words 8'h02 then 8'h80, MSB first (tail "10" + head "10" would form 1010 only across the boundary) → both res_count=0. det_reset is high between the words; no cross-word match.
- res_ready held low 5 cycles in REPORT → res_* stable, in_ready=0, det_reset=1, det_din=0. Accept on the first cycle res_ready=1; IDLE on the next cycle.
- reset_n pulsed low during SHIFT k=4 → all outputs at reset values immediately. After release, 8'h0A (MSB first) gives res_count=1, res_first_idx=7.
- TOT_W forced to 4 in a test configuration: repeated 8'hAA MSB-first words saturate tot_count at 15. tot_clr on the update edge → tot_count=3.
